// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding one UART transmitter, with message locking.
// Optional lock-revocation watchdog enabled by defining UART_ARB_LOCK_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [1:0] req_last,
  output logic [1:0] req_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       owner,
  output logic       locked,
  output logic       lock_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

  state_t state;
  logic   grant;
  logic   accept;
  logic   expire;

  if (LOCK_TIMEOUT == 0) begin : g_bad_timeout
    $error("LOCK_TIMEOUT must be nonzero");
  end

  // Locked owner keeps the grant; otherwise a lone requester wins, ties alternate.
  always_comb begin
    grant = ~owner;
    if (locked)                  grant = owner;
    else if (req_valid == 2'b01) grant = 1'b0;
    else if (req_valid == 2'b10) grant = 1'b1;
  end

  // Ready is combinational so a byte can be taken on the very first edge after reset.
  assign req_ready = (reset && state == IDLE) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = (reset && state == IDLE) && req_valid[grant];

`ifdef UART_ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);

  logic [CW-1:0] stall_cnt;
  logic          stall;

  assign stall  = (state == IDLE) && locked && !req_valid[owner];
  assign expire = stall && (stall_cnt == CW'(LOCK_TIMEOUT - 1));

  // Consecutive idle cycles in which the locked owner offers nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      lock_err  <= 1'b0;
    end else begin
      lock_err <= expire;
      if (stall && !expire) stall_cnt <= stall_cnt + CW'(1);
      else                  stall_cnt <= '0;
    end
  end
`else
  assign expire   = 1'b0;
  assign lock_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= 1'b1;
      locked   <= 1'b0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data  <= grant ? req_data1 : req_data0;
            owner    <= grant;
            locked   <= ~req_last[grant];
            tx_start <= 1'b1;
            state    <= START;
          end else if (expire) begin
            locked <= 1'b0;
          end
        end
        START:     state <= WAIT_ACK;
        WAIT_ACK:  if (tx_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 1024, giving the idle cycles a locked owner may stall before its lock is revoked (used only with the Configuration macro).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 2, one byte-valid flag per requester (bit 0 = echo path, bit 1 = message source).
REQ-005 SHALL have port req_data0 and req_data1, input, 8 each, the byte offered by each requester.
REQ-006 SHALL have port req_last, input, 2, per requester; 1 = offered byte ends its message.
REQ-007 SHALL have port req_ready, output, 2, per requester; a byte is accepted on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-008 SHALL have port tx_data, output, 8, the byte presented to the shared UART transmitter.
REQ-009 SHALL have port tx_start, output, 1, a one-cycle pulse requesting transmission of tx_data.
REQ-010 SHALL have port tx_busy, input, 1, high while the transmitter is shifting a frame.
REQ-011 SHALL have ports owner (output, 1, the requester last granted) and locked (output, 1, high while a multi-byte message is in progress).
REQ-012 SHALL have port lock_err, output, 1, a one-cycle pulse on lock revocation.

Function
REQ-013 SHALL implement the states IDLE, START, WAIT_ACK and WAIT_DONE.
REQ-014 In IDLE, SHALL drive req_ready high for exactly one requester, and only when a byte can be accepted; req_ready SHALL be 0 in every other state.
REQ-015 In IDLE while unlocked, with one requester valid, SHALL grant that requester.
REQ-016 In IDLE while unlocked, with both requesters valid, SHALL grant the requester not equal to owner (round-robin).
REQ-017 In IDLE while locked, SHALL offer req_ready only to owner and ignore the other requester.
REQ-018 On acceptance, SHALL register tx_data from the granted requester and update owner.
REQ-019 On acceptance, SHALL set locked to ~req_last[owner] and move to START.
REQ-020 In START, SHALL assert tx_start for exactly one cycle and then move to WAIT_ACK; acceptance-to-tx_start latency is 1 cycle.
REQ-021 In WAIT_ACK, SHALL wait for tx_busy=1 and then move to WAIT_DONE.
REQ-022 In WAIT_DONE, SHALL wait for tx_busy=0 and then return to IDLE.
REQ-023 SHALL hold tx_data stable from START until the return to IDLE.
REQ-024 Back-to-back bytes from one owner SHALL be accepted at most once per transmitted frame; the minimum spacing is 4 cycles plus the frame time.
REQ-025 If tx_busy is already 1 on entry to WAIT_ACK, SHALL move to WAIT_DONE on the next cycle.
REQ-026 Requester valid/data changes outside an acceptance cycle SHALL have no effect.

Reset
REQ-027 While reset=0, SHALL immediately force state=IDLE, owner=1 (so requester 0 wins the first tie), locked=0, tx_data=8'h00, tx_start=0, lock_err=0 and req_ready=0.
REQ-028 Reset asserted mid-frame SHALL abandon the byte and clear any lock; the transmitter is reset separately.
REQ-029 After reset deassertion, the first acceptance SHALL be possible on the first rising clk edge.

Configuration
REQ-030 With macro UART_ARB_LOCK_TIMEOUT_EN defined, SHALL count consecutive IDLE cycles with locked=1 and req_valid[owner]=0.
REQ-031 With UART_ARB_LOCK_TIMEOUT_EN defined, when that count reaches LOCK_TIMEOUT, SHALL clear locked, pulse lock_err for one cycle and reset the count.
REQ-032 With UART_ARB_LOCK_TIMEOUT_EN defined, any acceptance SHALL reset the count.
REQ-033 Without UART_ARB_LOCK_TIMEOUT_EN, a lock SHALL persist until a last byte is accepted, lock_err SHALL be constant 0 and no counter SHALL exist.

Verification
REQ-034 Single byte: req_valid=2'b01, req_data0=8'h41, last=1 -> tx_start pulse 1 cycle after acceptance, tx_data=8'h41, locked=0, owner=0.
REQ-035 Tie: both valid with last=1, data0=8'h31, data1=8'h32, repeated -> transmit order 8'h31, 8'h32, 8'h31, 8'h32.
REQ-036 Lock: req1 sends 8'h48, 8'h69 (last=0), then 8'h0A (last=1) while req0 stays valid -> req1's three bytes go out contiguously before req0 is granted.
REQ-037 Transmitter handshake: tx_busy held 0 for 10 cycles after tx_start -> FSM remains in WAIT_ACK and req_ready=2'b00 throughout.
REQ-038 Reset mid-frame: reset=0 during WAIT_DONE with locked=1 -> outputs immediately take their REQ-027 values, and the next grant follows the round-robin rules from reset.
REQ-039 Timeout (with macro, LOCK_TIMEOUT=16): owner locked with valid low for 16 IDLE cycles -> lock_err pulses once, locked=0, and the other requester is granted on the next cycle.
